// File: rtl/max_cpx_ingress_fifo.sv
// CPX ingress FIFO: host stream -> CCX bridge, first-word-fall-through head with registered flags.
// Optional build macro CPX_FIFO_STATS_EN adds saturating accepted/dropped write counters.
module max_cpx_ingress_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AEMPTY_TH    = 1,
  parameter int STALL_MARGIN = 2
) (
  input  logic        gclk,
  input  logic        reset,
  input  logic        host_cpx_valid,
  input  logic [31:0] host_cpx_data,
  input  logic [1:0]  host_cpx_ctl,
  output logic        host_cpx_stall,
  input  logic        max_cpx_read,
  output logic        max_cpx_valid,
  output logic [31:0] max_cpx_data,
  output logic [31:0] max_cpx_ctl_data,
  output logic        max_cpx_empty,
  output logic        max_cpx_almost_empty,
  output logic        cpx_overflow
`ifdef CPX_FIFO_STATS_EN
  ,
  output logic [15:0] stat_wr_cnt,
  output logic [15:0] stat_drop_cnt
`endif
);

  localparam logic [ADDR_W:0]   FULL_CNT   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AEMPTY_CNT = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0]   STALL_CNT  = (ADDR_W+1)'(DEPTH - STALL_MARGIN);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [33:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_drop;
  logic [33:0]       head;

  assign wr_acc  = host_cpx_valid && (count != FULL_CNT);
  assign wr_drop = host_cpx_valid && (count == FULL_CNT);
  assign rd_acc  = max_cpx_read && (count != '0);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage array carries no reset; only pointers and flags are control state.
  always_ff @(posedge gclk) begin
    if (wr_acc) mem[wr_ptr] <= {host_cpx_ctl, host_cpx_data};
  end

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
    end
  end

  // Flags are registered from next-count so they line up with the head entry.
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      max_cpx_empty        <= 1'b1;
      max_cpx_almost_empty <= 1'b1;
      max_cpx_valid        <= 1'b0;
      host_cpx_stall       <= 1'b0;
      cpx_overflow         <= 1'b0;
    end else begin
      max_cpx_empty        <= (count_nxt == '0);
      max_cpx_almost_empty <= (count_nxt <= AEMPTY_CNT);
      max_cpx_valid        <= (count_nxt != '0);
      host_cpx_stall       <= (count_nxt >= STALL_CNT);
      cpx_overflow         <= cpx_overflow | wr_drop;
    end
  end

  assign head             = mem[rd_ptr];
  assign max_cpx_data     = max_cpx_valid ? head[31:0] : 32'h0;
  assign max_cpx_ctl_data = max_cpx_valid ? {27'h0, head[33], head[32], 3'b000} : 32'h0;

`ifdef CPX_FIFO_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'h1;
  endfunction

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      stat_wr_cnt   <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (wr_acc)  stat_wr_cnt   <= sat_inc16(stat_wr_cnt);
      if (wr_drop) stat_drop_cnt <= sat_inc16(stat_drop_cnt);
    end
  end
`endif

endmodule
